// File: rtl/unidade_acesso_memoria_pkg.sv
// ctrl_pkg: shared FSM states, func3 size codes, latency limits and alignment check for the memory access unit.
package ctrl_pkg;
  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int CNT_W = $clog2(MEM_LAT_MAX);
  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
    return f3[1:0] == 2'd1 ? off[0] : f3[1:0] == 2'd2 ? |off[1:0] : f3[1:0] == 2'd3 ? |off : 1'b0;
  endfunction
endpackage

// File: rtl/unidade_acesso_memoria_load_extend.sv
// load_extend: pulls the addressed lane out of a doubleword and sign/zero-extends it to 64 bits.
module load_extend (
  input  logic [63:0] i_mem_rdata,
  input  logic [2:0]  i_offset,
  input  logic [2:0]  i_func3,
  output logic [63:0] o_ext
);
  logic [63:0] w_sh;
  logic        w_sgn;
  assign w_sh  = i_mem_rdata >> {i_offset, 3'b000};
  assign w_sgn = ~i_func3[2];
  assign o_ext = i_func3[1:0] == 2'd0 ? {{56{w_sgn & w_sh[7]}},  w_sh[7:0]}  :
                 i_func3[1:0] == 2'd1 ? {{48{w_sgn & w_sh[15]}}, w_sh[15:0]} :
                 i_func3[1:0] == 2'd2 ? {{32{w_sgn & w_sh[31]}}, w_sh[31:0]} : w_sh;
endmodule

// File: rtl/unidade_acesso_memoria.sv
// unidade_acesso_memoria: multicycle load/store sequencer with read-modify-write for partial stores.
module unidade_acesso_memoria
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  func3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata,
  output logic [63:0] mem_addr,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);
  state_t             r_state, w_next;
  logic               r_we, r_err;
  logic [2:0]         r_func3, r_off;
  logic [63:0]        r_wdata;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_bad;
  logic [63:0]        w_ext, w_lane, w_mask, w_merged;
  assign w_bad = func3 == 3'b111 || (we && func3[2]) || misaligned(func3, addr[2:0]);
  load_extend u_ext (
    .i_mem_rdata(mem_rdata),
    .i_offset   (r_off),
    .i_func3    (r_func3),
    .o_ext      (w_ext)
  );
  // Store merge keeps every byte of the fetched doubleword outside the addressed lane.
  assign w_lane   = r_func3[1:0] == 2'd0 ? 64'hFF : r_func3[1:0] == 2'd1 ? 64'hFFFF :
                    r_func3[1:0] == 2'd2 ? 64'hFFFF_FFFF : '1;
  assign w_mask   = w_lane << {r_off, 3'b000};
  assign w_merged = (mem_rdata & ~w_mask) | ((r_wdata << {r_off, 3'b000}) & w_mask);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !req ? IDLE : w_bad ? DONE : (we && func3 == F3_D) ? WRITE : READ;
      READ:    w_next = r_cnt == '0 ? MERGE : READ;
      MERGE:   w_next = r_we ? WRITE : DONE;
      WRITE:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    busy = r_state != IDLE;
    done = r_state == DONE;
    err  = done & r_err;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_func3   <= '0;
      r_off     <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      r_state <= w_next;
      mem_wr  <= w_next == WRITE;
      if (r_state == IDLE && req) begin
        r_we     <= we;
        r_func3  <= func3;
        r_off    <= addr[2:0];
        r_wdata  <= wdata;
        r_err    <= w_bad;
        r_cnt    <= CNT_W'(MEM_LAT - 1);
        mem_addr <= {addr[63:3], 3'b000};
        if (we) mem_wdata <= wdata;
      end
      if (r_state == READ && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (r_state == MERGE && r_we) mem_wdata <= w_merged;
      if (r_state == MERGE && !r_we) rdata <= w_ext;
    end
  end
endmodule

// File: tb/tb_unidade_acesso_memoria.sv
// tb_unidade_acesso_memoria: checks two instances (MEM_LAT 1 and 3) against a byte-level reference model.
module tb_unidade_acesso_memoria;
  logic        clk = 0, reset = 1;
  logic        we = 0;
  logic [2:0]  func3 = 0;
  logic [63:0] addr = 0, wdata = 0;
  logic        req [2];
  logic        busy [2], done [2], err [2], mem_wr [2];
  logic [63:0] rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
  logic [63:0] mem [2][256];
  logic [63:0] pipe [2][3];
  logic [63:0] rm [2][256];
  logic [63:0] exp_rd [2];
  logic        pl_en = 0;
  logic [7:0]  pl_idx = 0;
  logic [63:0] pl_val = 0;
  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  unidade_acesso_memoria #(.MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we), .func3(func3), .addr(addr), .wdata(wdata),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .rdata(rdata[0]), .mem_addr(mem_addr[0]),
    .mem_wr(mem_wr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]));
  unidade_acesso_memoria #(.MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we), .func3(func3), .addr(addr), .wdata(wdata),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .rdata(rdata[1]), .mem_addr(mem_addr[1]),
    .mem_wr(mem_wr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]));

  // Latency-L memory: data for the address seen in cycle c appears in cycle c+L.
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe[k][0] <= mem[k][mem_addr[k][10:3]];
      for (int i = 1; i < 3; i++) pipe[k][i] <= pipe[k][i-1];
      if (pl_en) mem[k][pl_idx] <= pl_val;
      else if (mem_wr[k]) mem[k][mem_addr[k][10:3]] <= mem_wdata[k];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(input logic [63:0] dw, input logic [2:0] f3, input logic [2:0] off);
    int n = 1 << f3[1:0];
    logic [63:0] v = dw >> (8 * off);
    if (n < 8) begin
      v &= (64'd1 << (8 * n)) - 1;
      if (!f3[2] && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 1);
    end
    return v;
  endfunction

  function automatic logic [63:0] ref_store(input logic [63:0] dw, input logic [63:0] wd, input logic [2:0] f3, input logic [2:0] off);
    int n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) dw[8*(off+i) +: 8] = wd[8*i +: 8];
    return dw;
  endfunction

  task automatic access(input int k, input logic w, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input logic hold);
    int L = k ? 3 : 1;
    int n = 1 << f3[1:0];
    logic bad;
    int e_done, e_wr, d1 = 0, d2 = 0, wr_n = 0, wr_c = 0;
    logic err_seen = 0;
    logic [7:0] idx = a[10:3];
    logic [63:0] old = rm[k][idx];
    bad = f3 == 3'b111 || (w && f3[2]) || (a % n != 0);
    e_done = bad ? 1 : (w && f3 == 3'b011) ? 2 : w ? L + 3 : L + 2;
    e_wr = (bad || !w) ? 0 : f3 == 3'b011 ? 1 : L + 2;
    we = w; func3 = f3; addr = a; wdata = wd; req[k] = 1;
    for (int c = 1; c <= 30 && (hold ? d2 == 0 : d1 == 0); c++) begin
      @(posedge clk); #1;
      if (!hold) req[k] = 0;
      @(negedge clk);
      if (c == 1) check("mem_addr", mem_addr[k], {a[63:3], 3'b000});
      if (mem_wr[k]) begin wr_n++; wr_c = c; end
      if (done[k]) begin
        if (d1 == 0) begin d1 = c; err_seen = err[k]; end
        else d2 = c;
      end
    end
    req[k] = 0;
    if (!bad && w) rm[k][idx] = ref_store(old, wd, f3, a[2:0]);
    if (!bad && !w) exp_rd[k] = ref_load(old, f3, a[2:0]);
    check("done_cycle", 64'(d1), 64'(e_done));
    check("err", {63'b0, err_seen}, {63'b0, bad});
    check("wr_count", 64'(wr_n), e_wr != 0 ? 64'd1 : 64'd0);
    if (e_wr != 0) check("wr_cycle", 64'(wr_c), 64'(e_wr));
    if (hold) check("second_done", 64'(d2), 64'(2 * e_done + 1));
    check("rdata", rdata[k], exp_rd[k]);
    check("mem_word", mem[k][idx], rm[k][idx]);
    @(negedge clk);
  endtask

  initial begin
    int wr_n;
    req[0] = 1; req[1] = 1;
    addr = 64'h123; wdata = 64'hDEAD; we = 1; func3 = 3'b001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", {63'b0, busy[k]}, 64'd0);
      check("rst_done", {63'b0, done[k]}, 64'd0);
      check("rst_err", {63'b0, err[k]}, 64'd0);
      check("rst_rdata", rdata[k], 64'd0);
      check("rst_mem_addr", mem_addr[k], 64'd0);
      check("rst_mem_wr", {63'b0, mem_wr[k]}, 64'd0);
      check("rst_mem_wdata", mem_wdata[k], 64'd0);
      exp_rd[k] = 0;
    end
    reset = 0; req[0] = 0; req[1] = 0;
    @(negedge clk);
    check("idle_after_rst", {63'b0, busy[0] | busy[1]}, 64'd0);
    for (int i = 0; i < 256; i++) begin
      pl_val = i == 32 ? 64'h8877665544332211 : {$urandom, $urandom};
      pl_idx = 8'(i); pl_en = 1;
      rm[0][i] = pl_val; rm[1][i] = pl_val;
      @(negedge clk);
    end
    pl_en = 0;
    @(negedge clk);
    access(0, 0, 3'b011, 64'h100, 0, 0);
    check("ld_literal", rdata[0], 64'h8877665544332211);
    access(0, 0, 3'b000, 64'h107, 0, 0);
    check("lb_literal", rdata[0], 64'hFFFFFFFFFFFFFF88);
    access(0, 0, 3'b100, 64'h107, 0, 0);
    access(0, 0, 3'b001, 64'h106, 0, 0);
    access(0, 0, 3'b110, 64'h104, 0, 0);
    check("lwu_literal", rdata[0], 64'h88776655);
    access(0, 1, 3'b000, 64'h102, 64'h1234_5678_9ABC_DEAB, 0);
    check("sb_literal", mem[0][32], 64'h8877665544AB2211);
    access(0, 1, 3'b011, 64'h100, 64'h1, 0);
    access(0, 0, 3'b010, 64'h102, 0, 0);
    access(0, 1, 3'b100, 64'h100, 64'hFF, 0);
    we = 1; func3 = 3'b001; addr = 64'h100; wdata = 64'hBEEF; req[0] = 1;
    @(posedge clk); #1 req[0] = 0;
    @(negedge clk);
    check("midop_busy", {63'b0, busy[0]}, 64'd1);
    reset = 1;
    @(posedge clk); #1 reset = 0;
    wr_n = 0;
    @(negedge clk);
    check("midop_idle", {63'b0, busy[0]}, 64'd0);
    for (int c = 0; c < 6; c++) begin
      if (mem_wr[0]) wr_n++;
      @(negedge clk);
    end
    check("midop_no_wr", 64'(wr_n), 64'd0);
    check("midop_mem", mem[0][32], rm[0][32]);
    exp_rd[0] = 0; exp_rd[1] = 0;
    check("midop_rdata", rdata[0], 64'd0);
    access(1, 0, 3'b011, 64'h100, 0, 0);
    access(1, 0, 3'b011, 64'h100, 0, 1);
    repeat (80) begin
      int k = $urandom_range(0, 1);
      logic w = 1'($urandom_range(0, 1));
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      logic [63:0] a = 64'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) != 0) a &= ~(64'(1 << f3[1:0]) - 1);
      access(k, w, f3, a, {$urandom, $urandom}, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/unidade_acesso_memoria.md
# unidade_acesso_memoria

Multicycle load/store sequencer between the control unit's memory states and the 64-bit doubleword-wide data memory. It accepts one access request at a time and handles byte, half, word and doubleword sizes. Partial stores use read-modify-write. Load results are sign- or zero-extended, and misaligned or illegal accesses are flagged without touching memory. Address and store data come from the ALU-out and B registers; the extended result goes to the MDR/register-file write path.

## Interface
- MEM_LAT, 1: memory read latency in cycles (1..4); mem_rdata valid MEM_LAT cycles after mem_addr is first presented
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  1  access request; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- func3  in  3  size/sign:
  - 000 b, 001 h, 010 w, 011 d
  - 100 bu, 101 hu, 110 wu (load only)
- addr  in  64  byte address
- wdata  in  64  store data, right-aligned
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid only with done; misaligned or illegal access
- rdata  out  64  extended load result; updated only on a successful load; holds until the next successful load
- mem_addr  out  64  {addr[63:3], 3'b000}
- mem_wr  out  1  memory write strobe
- mem_wdata  out  64  full doubleword to write
- mem_rdata  in  64  memory read data

## Operation
- **IDLE.** When req=1:
  - Latch we, func3, addr and wdata. Later input changes are ignored until the next IDLE.
  - Legality check, evaluated from the latched inputs:
    - Illegal: func3=111, or a store with func3[2]=1.
    - Misaligned: h/hu with addr[0]≠0; w/wu with addr[1:0]≠0; d with addr[2:0]≠0.
  - Next state:
    - Illegal or misaligned → DONE with err=1.
    - Aligned sd → WRITE.
    - Otherwise → READ, with the counter loaded to MEM_LAT-1.
- **READ.** Present mem_addr with mem_wr=0. Decrement the counter; move to MERGE when the count reaches 0.
- **MERGE.** mem_rdata is valid in this cycle.
  - Load: extract the lane at byte offset addr[2:0], sign- or zero-extend to 64 bits, register into rdata.
  - Store: replace only the addressed bytes of mem_rdata with the low bytes of wdata, register the result into mem_wdata, then go to WRITE.
  - Load goes to DONE.
- **WRITE.** mem_wr=1 for exactly one cycle.
  - For sd, mem_wdata = wdata.
  - Then go to DONE.
- **DONE.** done=1 for one cycle, with err as decided in IDLE. Then return to IDLE.
- **Request handling.**
  - req while busy: ignored, not queued.
  - req held high through DONE: accepted in the following IDLE cycle, so there is a minimum one-cycle gap between accesses.
- **Reset.**
  - Takes effect at the next clock edge from any state; returns to IDLE.
  - A pending store is abandoned and mem_wr is never asserted for it.
- **Reset values:** busy 0, done 0, err 0, rdata 0, mem_addr 0, mem_wr 0, mem_wdata 0, counter 0.

## Timing
Cycle 0 is the IDLE cycle in which req=1; L = MEM_LAT.
- Load: READ in cycles 1..L, MERGE in cycle L+1, done in cycle L+2. rdata is valid from cycle L+2.
- Partial store: READ in cycles 1..L, MERGE in cycle L+1, mem_wr in cycle L+2, done in cycle L+3.
- Aligned sd: mem_wr in cycle 1, done in cycle 2.
- Error: done=1 and err=1 in cycle 1. No READ and no mem_wr.
- mem_addr, mem_wr and mem_wdata are registered outputs.
- mem_addr is stable from cycle 1 until DONE.
- The memory samples mem_wdata and mem_addr on the clock edge that ends the WRITE cycle.

## Structure
- **Shared package (ctrl_pkg):**
  - State enum: IDLE, READ, MERGE, WRITE, DONE.
  - func3 size-code constants.
  - MEM_LAT range limits.
  - Alignment-check function.
- **Sub-module load_extend (combinational):** inputs mem_rdata, offset and func3; output is the 64-bit extended value.
- Store-side byte merge is done in the top level.
- The FSM lives in the top level.

## Test plan
Preload memory: address 0x100 holds 0x8877665544332211. MEM_LAT=1 unless stated.

1. **Reset values.** Assert reset for 2 cycles with req=1 → all outputs 0; state IDLE one cycle after reset is released.
2. **Load extension.**
   - ld 0x100 → done in cycle 3, rdata=0x8877665544332211.
   - lb 0x107 → 0xFFFFFFFFFFFFFF88.
   - lbu 0x107 → 0x88.
   - lh 0x106 → 0xFFFFFFFFFFFF8877.
   - lwu 0x104 → 0x88776655.
3. **Stores.**
   - sb 0x102 with wdata=0x..AB → single mem_wr pulse in cycle 3, memory becomes 0x8877665544AB2211, done in cycle 4.
   - sd 0x100 with wdata=0x1 → mem_wr in cycle 1, done in cycle 2.
4. **Errors.**
   - lw 0x102 → done=err=1 in cycle 1, no mem_wr, rdata unchanged.
   - sb with func3=100 → err=1.
5. **Reset mid-operation.** sh 0x100 with reset asserted in cycle 1 → IDLE at the next edge, mem_wr never asserted, memory unchanged.
6. **MEM_LAT=3.**
   - ld 0x100 → done in cycle 5.
   - req held high continuously → second access accepted in cycle 6, done in cycle 11.
